esaxi_rd_beat_gen: RTL
======================

# esaxi_rd_beat_gen

Per-beat read engine downstream of the AXI slave read-channel bridge. It takes the committed burst descriptor (`tx_araddr`, `tx_arlen`, `tx_arsize`, `tx_arburst`, `tx_ractive`) and issues one eMesh read request per beat, with credit-limited outstanding tracking. eMesh read responses are buffered in order and returned to the bridge as `read_valid`/`read_data_*`/`read_resp`.

## Interface
- `MAX_OUTSTANDING`, 4 — response FIFO depth and maximum in-flight requests (power of 2, 2..16)
- `SRC_ADDR`, 32'h810F_0000 — return address placed in `emrq_srcaddr`
- `TIMEOUT_CYCLES`, 255 — response timeout, used only with `ESAXI_RD_TIMEOUT_EN`

Ports:
- `clk` in 1 — sole clock
- `s_axi_aresetn` in 1 — synchronous, active-low reset
- `tx_ractive` in 1 — burst active from bridge; rising edge starts a burst
- `tx_araddr` in 32 — burst start address
- `tx_arlen` in 8 — beats minus 1
- `tx_arsize` in 3 — beat size
- `tx_arburst` in 2 — 01 INCR, otherwise FIXED
- `beat_ack` in 1 — bridge consumed the current beat (`s_axi_rvalid & s_axi_rready`)
- `emrq_access` out 1 — read request valid
- `emrq_datamode` out 2 — `tx_arsize` clipped to 2
- `emrq_dstaddr` out 32 — beat address
- `emrq_srcaddr` out 32 — `SRC_ADDR`
- `emrq_wait` in 1 — eMesh backpressure
- `emrr_access` in 1 — response valid
- `emrr_data` in 32 — response data, right-justified
- `read_valid` out 1 — FIFO head valid
- `read_data_7_0` / `read_data_15_0` / `read_data_31_0` out 8/16/32 — head data slices
- `read_resp` out 2 — head response code
- `rr_unexpected` out 1 — sticky: response arrived with zero outstanding

## Operation
- States: IDLE, ISSUE, DRAIN.
- `start` = `tx_ractive` high and previous-cycle `tx_ractive` low.
- IDLE + `start`:
  - latch address, `tx_arsize`, and `tx_arburst`
  - set `beats_left` (9-bit) = `tx_arlen` + 1
  - go to ISSUE
- ISSUE issues a request when `credits_ok` = (outstanding + fifo_count < `MAX_OUTSTANDING`) and `beats_left` != 0.
- Request hold: `emrq_access` and the request fields stay stable while `emrq_wait`=1. A request is accepted on any cycle with `emrq_access`=1 and `emrq_wait`=0.
- On accept:
  - outstanding +1 and `beats_left` −1
  - INCR: next address = {addr[31:2]+1, 2'b00}
  - FIXED: address unchanged
- When `beats_left` reaches 0, go to DRAIN.
- `tx_ractive` falling while in ISSUE aborts the burst: go to DRAIN and issue nothing further.
- DRAIN → IDLE when outstanding = 0. A `start` seen during DRAIN is latched (`start_pending`) and taken on entry to IDLE.
- `emrr_access` with outstanding>0:
  - push {`emrr_data`, 2'b00} into the FIFO
  - outstanding −1
  - if the burst was aborted, discard the data instead of pushing it
- `emrr_access` with outstanding=0: drop the response and set `rr_unexpected`.
- FIFO interface:
  - `read_valid` = FIFO not empty
  - `read_data_31_0` = head; `read_data_15_0` = head[15:0]; `read_data_7_0` = head[7:0]
  - `beat_ack` pops the head; `beat_ack` on an empty FIFO is ignored
- Simultaneous push and pop: both occur and the count is unchanged. Simultaneous accept and response: outstanding is unchanged.
- Counters: outstanding and fifo_count are each log2(`MAX_OUTSTANDING`)+1 bits and never wrap.

## Timing
- Reset values: every output 0 except `emrq_srcaddr` = `SRC_ADDR`. State IDLE, FIFO empty, counters 0, `rr_unexpected` 0.
- Reset at any point, including mid-burst, abandons all state in one cycle.
- `start` detected at edge N → `emrq_access`=1 from cycle N+1.
- Back-to-back requests, one per cycle, while credits are available and `emrq_wait`=0.
- Response to read: `emrr_access` at edge M → `read_valid`=1 in cycle M+1 (registered FIFO, no bypass).
- Pop at edge P → next head, or `read_valid`=0, visible in cycle P+1.

## Configuration
- `ESAXI_RD_TIMEOUT_EN` defined:
  - a counter runs while outstanding>0 with no `emrr_access`, and clears on any response
  - on reaching `TIMEOUT_CYCLES`, it pushes {32'h0, 2'b10} (SLVERR), decrements outstanding, and clears
  - the synthesized entry is pushed even when the burst is aborted, so DRAIN always terminates
- Undefined:
  - no counter; the engine waits indefinitely
  - `read_resp` is always 2'b00
  - `TIMEOUT_CYCLES` is unused

## Test plan
- Single beat: `tx_araddr`=0x1000, `tx_arlen`=0, `tx_arsize`=2 → one request with `dstaddr` 0x1000, `datamode` 2. Response 0xDEADBEEF → `read_valid`=1, `read_data_31_0`=0xDEADBEEF, `read_data_7_0`=0xEF, `read_resp`=0. `beat_ack` → `read_valid`=0 and state returns to IDLE.
- INCR burst: `tx_araddr`=0x2002, `tx_arlen`=3, `tx_arburst`=01 → `dstaddr` sequence 0x2002, 0x2004, 0x2008, 0x200C. A FIXED burst with the same inputs gives 0x2002 ×4.
- Credit limit: `MAX_OUTSTANDING`=4, `tx_arlen`=7, no responses → exactly 4 accepts, then `emrq_access`=0. One response plus `beat_ack` → a fifth request follows.
- Backpressure: `emrq_wait`=1 for 3 cycles on beat 0 → `emrq_access` and `dstaddr` held stable. Accept occurs on the first cycle with `emrq_wait`=0, with no duplicate request.
- Abort and reset: drop `tx_ractive` after 2 of 4 requests → no further requests; 2 responses are discarded; state returns to IDLE. A stray response then sets `rr_unexpected`. Reset mid-burst → all outputs return to reset values next cycle.
- Timeout (`ESAXI_RD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): one request, no response → after 8 cycles `read_valid`=1, `read_data_31_0`=0, `read_resp`=2'b10.

Source files
------------

// File: rtl/esaxi_rd_beat_gen.sv
// esaxi_rd_beat_gen: issues one eMesh read per AXI beat under a credit limit and returns
// responses in order through a registered FIFO. Define ESAXI_RD_TIMEOUT_EN for the response timeout.
module esaxi_rd_beat_gen #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] SRC_ADDR        = 32'h810F_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        s_axi_aresetn,
  input  logic        tx_ractive,
  input  logic [31:0] tx_araddr,
  input  logic [7:0]  tx_arlen,
  input  logic [2:0]  tx_arsize,
  input  logic [1:0]  tx_arburst,
  input  logic        beat_ack,
  output logic        emrq_access,
  output logic [1:0]  emrq_datamode,
  output logic [31:0] emrq_dstaddr,
  output logic [31:0] emrq_srcaddr,
  input  logic        emrq_wait,
  input  logic        emrr_access,
  input  logic [31:0] emrr_data,
  output logic        read_valid,
  output logic [7:0]  read_data_7_0,
  output logic [15:0] read_data_15_0,
  output logic [31:0] read_data_31_0,
  output logic [1:0]  read_resp,
  output logic        rr_unexpected
);

  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] MAX_SUM = (CW+1)'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of 2 in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           tx_ractive_q, tx_ractive_d;
  logic [31:0]    addr_q, addr_d;
  logic [1:0]     burst_q, burst_d;
  logic [1:0]     datamode_q, datamode_d;
  logic [8:0]     beats_left_q, beats_left_d;
  logic           aborted_q, aborted_d;
  logic           start_pending_q, start_pending_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  fifo_count_q, fifo_count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [33:0]    mem_q [MAX_OUTSTANDING];
  logic [33:0]    mem_d [MAX_OUTSTANDING];
  logic           emrq_access_q, emrq_access_d;
  logic           read_valid_q, read_valid_d;
  logic [33:0]    head_q, head_d;
  logic           rr_unexpected_q, rr_unexpected_d;

  logic           start_s, fall_s, accept_s, rsp_ok_s, rsp_dec_s;
  logic           push_s, pop_s, timeout_fire_s;
  logic [33:0]    push_entry_s;
  logic [CW:0]    credit_sum_s;

`ifdef ESAXI_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts idle cycles while requests are in flight; expiry synthesizes an SLVERR beat.
  always_comb begin
    timeout_fire_s = 1'b0;
    to_cnt_d       = to_cnt_q;
    if (outstanding_q == {CW{1'b0}} || emrr_access) begin
      to_cnt_d = {TW{1'b0}};
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout_fire_s = 1'b1;
      to_cnt_d       = {TW{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TW'(1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!s_axi_aresetn) begin
      to_cnt_q <= {TW{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_fire_s = 1'b0;
`endif

  // Next-state computation for the issue FSM, credit counters and response FIFO.
  always_comb begin
    start_s   = tx_ractive & ~tx_ractive_q;
    fall_s    = ~tx_ractive & tx_ractive_q;
    accept_s  = emrq_access_q & ~emrq_wait;
    rsp_ok_s  = emrr_access & (outstanding_q != {CW{1'b0}});
    rsp_dec_s = rsp_ok_s | timeout_fire_s;
    // Aborted-burst data is dropped, but a timeout entry is always kept so DRAIN can finish.
    push_s    = (rsp_ok_s & ~aborted_q) | timeout_fire_s;
    pop_s     = beat_ack & (fifo_count_q != {CW{1'b0}});
    push_entry_s = timeout_fire_s ? {32'h0000_0000, 2'b10} : {emrr_data, 2'b00};

    tx_ractive_d    = tx_ractive;
    state_d         = state_q;
    addr_d          = addr_q;
    burst_d         = burst_q;
    datamode_d      = datamode_q;
    beats_left_d    = beats_left_q;
    aborted_d       = aborted_q;
    start_pending_d = start_pending_q;
    rr_unexpected_d = rr_unexpected_q | (emrr_access & (outstanding_q == {CW{1'b0}}));

    case ({accept_s, rsp_dec_s})
      2'b10:   outstanding_d = outstanding_q + CW'(1'b1);
      2'b01:   outstanding_d = outstanding_q - CW'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1'b1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1'b1);
      default: fifo_count_d = fifo_count_q;
    endcase

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_entry_s;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (accept_s) begin
      beats_left_d = beats_left_q - 9'd1;
      if (burst_q == 2'b01) begin
        addr_d = {addr_q[31:2] + 30'd1, 2'b00};
      end else begin
        addr_d = addr_q;
      end
    end else begin
      beats_left_d = beats_left_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_s || start_pending_q) begin
          addr_d          = tx_araddr;
          burst_d         = tx_arburst;
          datamode_d      = (tx_arsize > 3'd2) ? 2'd2 : tx_arsize[1:0];
          beats_left_d    = {1'b0, tx_arlen} + 9'd1;
          aborted_d       = 1'b0;
          start_pending_d = 1'b0;
          state_d         = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (fall_s) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (beats_left_d == 9'd0) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (start_s) begin
          start_pending_d = 1'b1;
        end else begin
          start_pending_d = start_pending_q;
        end
        if (outstanding_q == {CW{1'b0}}) begin
          aborted_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    credit_sum_s  = {1'b0, outstanding_d} + {1'b0, fifo_count_d};
    emrq_access_d = (state_d == S_ISSUE) && (beats_left_d != 9'd0) && (credit_sum_s < MAX_SUM);
    read_valid_d  = (fifo_count_d != {CW{1'b0}});
    head_d        = mem_d[rd_ptr_d];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!s_axi_aresetn) begin
      state_q         <= S_IDLE;
      tx_ractive_q    <= 1'b0;
      addr_q          <= 32'h0000_0000;
      burst_q         <= 2'b00;
      datamode_q      <= 2'b00;
      beats_left_q    <= 9'd0;
      aborted_q       <= 1'b0;
      start_pending_q <= 1'b0;
      outstanding_q   <= {CW{1'b0}};
      fifo_count_q    <= {CW{1'b0}};
      wr_ptr_q        <= {AW{1'b0}};
      rd_ptr_q        <= {AW{1'b0}};
      mem_q           <= '{default: 34'd0};
      emrq_access_q   <= 1'b0;
      read_valid_q    <= 1'b0;
      head_q          <= 34'd0;
      rr_unexpected_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_ractive_q    <= tx_ractive_d;
      addr_q          <= addr_d;
      burst_q         <= burst_d;
      datamode_q      <= datamode_d;
      beats_left_q    <= beats_left_d;
      aborted_q       <= aborted_d;
      start_pending_q <= start_pending_d;
      outstanding_q   <= outstanding_d;
      fifo_count_q    <= fifo_count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      mem_q           <= mem_d;
      emrq_access_q   <= emrq_access_d;
      read_valid_q    <= read_valid_d;
      head_q          <= head_d;
      rr_unexpected_q <= rr_unexpected_d;
    end
  end

  assign emrq_access    = emrq_access_q;
  assign emrq_datamode  = datamode_q;
  assign emrq_dstaddr   = addr_q;
  assign emrq_srcaddr   = SRC_ADDR;
  assign read_valid     = read_valid_q;
  assign read_data_31_0 = head_q[33:2];
  assign read_data_15_0 = head_q[17:2];
  assign read_data_7_0  = head_q[9:2];
  assign read_resp      = head_q[1:0];
  assign rr_unexpected  = rr_unexpected_q;

endmodule
